fust_issue_scheduler: RTL and testbench

// Owns per-FU status rows (state + operand tags) written by dispatch; picks one ready row per

---
 rtl/fust_issue_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fust_issue_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fust_issue_scheduler.sv
// Per-FU status table: dispatch allocates rows, writeback wakes operand tags, and a
// round-robin picker offers one READY row per cycle to execute.
module fust_issue_scheduler #(
    parameter int NUM_FU = 5,
    parameter int TAG_W  = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      alloc_en,
    input  logic [$clog2(NUM_FU)-1:0] alloc_fu,
    input  logic [TAG_W-1:0]          alloc_t1,
    input  logic [TAG_W-1:0]          alloc_t2,
    input  logic                      wb_en,
    input  logic [TAG_W-1:0]          wb_tag,
    input  logic                      issue_ready,
    input  logic                      done_en,
    input  logic [$clog2(NUM_FU)-1:0] done_fu,
    input  logic                      flush,
    input  logic                      freeze,
    output logic                      issue_valid,
    output logic [$clog2(NUM_FU)-1:0] issue_fu,
    output logic [NUM_FU*2-1:0]       fust_state,
    output logic                      alloc_err
);

    localparam int FU_W = $clog2(NUM_FU);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_READY  = 2'd2,
        S_ISSUED = 2'd3
    } row_state_t;

    row_state_t       r_state [NUM_FU];
    logic [TAG_W-1:0] r_t1    [NUM_FU];
    logic [TAG_W-1:0] r_t2    [NUM_FU];
    logic [FU_W-1:0]  r_rr_ptr;
    logic             r_alloc_err;

    row_state_t       w_state_nxt [NUM_FU];
    logic [TAG_W-1:0] w_t1_nxt    [NUM_FU];
    logic [TAG_W-1:0] w_t2_nxt    [NUM_FU];
    logic [FU_W-1:0]  w_rr_nxt;

    logic [NUM_FU-1:0] w_cand;
    logic [NUM_FU-1:0] w_done_hit;
    logic [NUM_FU-1:0] w_alloc_hit;
    logic [NUM_FU-1:0] w_row_free;
    logic              w_wb_hit;
    logic              w_alloc_ok;
    logic              w_alloc_bad;
    logic              w_grant;
    logic [TAG_W-1:0]  w_eff_t1;
    logic [TAG_W-1:0]  w_eff_t2;
    int                w_idx;

    // A producer completing in the same cycle as the alloc is bypassed into the row.
    assign w_wb_hit = wb_en && (wb_tag != '0);
    assign w_eff_t1 = (w_wb_hit && (alloc_t1 == wb_tag)) ? '0 : alloc_t1;
    assign w_eff_t2 = (w_wb_hit && (alloc_t2 == wb_tag)) ? '0 : alloc_t2;

    always_comb begin
        w_cand      = '0;
        w_done_hit  = '0;
        w_alloc_hit = '0;
        w_row_free  = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_cand[i]      = (r_state[i] == S_READY) && !freeze;
            w_done_hit[i]  = done_en && (done_fu == FU_W'(i)) && (r_state[i] == S_ISSUED);
            w_alloc_hit[i] = alloc_en && (alloc_fu == FU_W'(i));
            w_row_free[i]  = (r_state[i] == S_IDLE) || w_done_hit[i];
        end
    end

    // Out-of-range alloc_fu matches no row, so it lands in the error path.
    assign w_alloc_ok  = alloc_en && !flush && (|(w_alloc_hit & w_row_free));
    assign w_alloc_bad = alloc_en && !flush && !(|(w_alloc_hit & w_row_free));

    always_comb begin
        issue_valid = 1'b0;
        issue_fu    = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_FU) w_idx = w_idx - NUM_FU;
            if (!issue_valid && w_cand[w_idx]) begin
                issue_valid = 1'b1;
                issue_fu    = FU_W'(w_idx);
            end
        end
    end

    assign w_grant = issue_valid && issue_ready && !flush;

    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_grant) begin
            w_rr_nxt = (issue_fu == FU_W'(NUM_FU - 1)) ? '0 : issue_fu + FU_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            w_state_nxt[i] = r_state[i];
            w_t1_nxt[i]    = r_t1[i];
            w_t2_nxt[i]    = r_t2[i];
            if (flush) begin
                if ((r_state[i] == S_WAIT) || (r_state[i] == S_READY) || w_done_hit[i]) begin
                    w_state_nxt[i] = S_IDLE;
                    w_t1_nxt[i]    = '0;
                    w_t2_nxt[i]    = '0;
                end
            end else if (w_alloc_ok && w_alloc_hit[i]) begin
                w_t1_nxt[i]    = w_eff_t1;
                w_t2_nxt[i]    = w_eff_t2;
                w_state_nxt[i] = ((w_eff_t1 != '0) || (w_eff_t2 != '0)) ? S_WAIT : S_READY;
            end else begin
                case (r_state[i])
                    S_WAIT: begin
                        if (w_wb_hit && (r_t1[i] == wb_tag)) w_t1_nxt[i] = '0;
                        if (w_wb_hit && (r_t2[i] == wb_tag)) w_t2_nxt[i] = '0;
                        if ((w_t1_nxt[i] == '0) && (w_t2_nxt[i] == '0)) w_state_nxt[i] = S_READY;
                    end
                    S_READY: begin
                        if (w_grant && (issue_fu == FU_W'(i))) w_state_nxt[i] = S_ISSUED;
                    end
                    S_ISSUED: begin
                        if (w_done_hit[i]) begin
                            w_state_nxt[i] = S_IDLE;
                            w_t1_nxt[i]    = '0;
                            w_t2_nxt[i]    = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= S_IDLE;
                r_t1[i]    <= '0;
                r_t2[i]    <= '0;
            end
            r_rr_ptr    <= '0;
            r_alloc_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_t1[i]    <= w_t1_nxt[i];
                r_t2[i]    <= w_t2_nxt[i];
            end
            r_rr_ptr    <= w_rr_nxt;
            r_alloc_err <= w_alloc_bad;
        end
    end

    always_comb begin
        fust_state = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fust_state[2*i +: 2] = r_state[i];
        end
    end

    assign alloc_err = r_alloc_err;

endmodule

// File: tb/tb_fust_issue_scheduler.sv
// Directed bench for fust_issue_scheduler: alloc/wakeup/issue/done/flush/freeze
// sequences with hand-computed row states and issue choices.
module tb_fust_issue_scheduler;

    localparam int NUM_FU = 5;
    localparam int TAG_W  = 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             alloc_en = 1'b0;
    logic [2:0]       alloc_fu = '0;
    logic [TAG_W-1:0] alloc_t1 = '0;
    logic [TAG_W-1:0] alloc_t2 = '0;
    logic             wb_en = 1'b0;
    logic [TAG_W-1:0] wb_tag = '0;
    logic             issue_ready = 1'b0;
    logic             done_en = 1'b0;
    logic [2:0]       done_fu = '0;
    logic             flush = 1'b0;
    logic             freeze = 1'b0;
    logic             issue_valid;
    logic [2:0]       issue_fu;
    logic [NUM_FU*2-1:0] fust_state;
    logic             alloc_err;

    int n_cmp = 0;
    int n_err = 0;

    fust_issue_scheduler #(.NUM_FU(NUM_FU), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RST(RST),
        .alloc_en(alloc_en), .alloc_fu(alloc_fu), .alloc_t1(alloc_t1), .alloc_t2(alloc_t2),
        .wb_en(wb_en), .wb_tag(wb_tag), .issue_ready(issue_ready),
        .done_en(done_en), .done_fu(done_fu), .flush(flush), .freeze(freeze),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .fust_state(fust_state),
        .alloc_err(alloc_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] st(input int i);
        return fust_state[2*i +: 2];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample at the same point.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic alloc(input logic en, input int fu, input int t1, input int t2);
        alloc_en = en;
        alloc_fu = 3'(fu);
        alloc_t1 = TAG_W'(t1);
        alloc_t2 = TAG_W'(t2);
    endtask

    task automatic done(input logic en, input int fu);
        done_en = en;
        done_fu = 3'(fu);
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_state", 32'(fust_state), 32'h0);
        check("reset_valid", 32'(issue_valid), 32'h0);
        check("reset_fu", 32'(issue_fu), 32'h0);
        check("reset_err", 32'(alloc_err), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Ready alloc issues one cycle later, then retires on done
        alloc(1, 2, 0, 0);
        issue_ready = 1'b1;
        tick();
        alloc(0, 0, 0, 0);
        check("t2_valid", 32'(issue_valid), 32'h1);
        check("t2_fu", 32'(issue_fu), 32'h2);
        check("t2_s2_ready", 32'(st(2)), 32'h2);
        tick();
        check("t2_s2_issued", 32'(st(2)), 32'h3);
        check("t2_valid_after", 32'(issue_valid), 32'h0);
        done(1, 2);
        issue_ready = 1'b0;
        tick();
        done(0, 0);
        check("t2_s2_idle", 32'(st(2)), 32'h0);

        // Wakeup by writeback, and same-cycle alloc bypass (rr_ptr is 3 here)
        alloc(1, 1, 2, 3);
        tick();
        alloc(0, 0, 0, 0);
        check("t3_s1_wait", 32'(st(1)), 32'h1);
        check("t3_valid0", 32'(issue_valid), 32'h0);
        wb_en = 1'b1; wb_tag = 2'd2;
        tick();
        check("t3_s1_still_wait", 32'(st(1)), 32'h1);
        wb_tag = 2'd3;
        tick();
        check("t3_s1_ready", 32'(st(1)), 32'h2);
        check("t3_fu1", 32'(issue_fu), 32'h1);
        wb_tag = 2'd1;
        alloc(1, 4, 1, 0);
        tick();
        alloc(0, 0, 0, 0);
        wb_en = 1'b0; wb_tag = '0;
        check("t3_s4_bypass_ready", 32'(st(4)), 32'h2);
        check("t3_rr_pick4", 32'(issue_fu), 32'h4);

        // Issue rows 4 then 1; set up rows 1,3 ISSUED
        issue_ready = 1'b1;
        tick();
        check("t1_s4_issued", 32'(st(4)), 32'h3);
        check("t1_next_fu1", 32'(issue_fu), 32'h1);
        tick();
        check("t1_s1_issued", 32'(st(1)), 32'h3);
        issue_ready = 1'b0;
        done(1, 4);
        alloc(1, 3, 0, 0);
        tick();
        done(0, 0);
        alloc(0, 0, 0, 0);
        check("t1_s4_idle", 32'(st(4)), 32'h0);
        check("t1_s3_ready", 32'(st(3)), 32'h2);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("t1_state_pre", 32'(fust_state), 32'h0CC);

        // Asynchronous reset mid-cycle
        #2;
        RST = 1'b1;
        #1;
        check("t1_rst_state", 32'(fust_state), 32'h0);
        check("t1_rst_valid", 32'(issue_valid), 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Round-robin 0,2,4 with a freeze cycle
        @(posedge CLK); #1;
        alloc(1, 0, 0, 0);
        tick();
        alloc(1, 2, 0, 0);
        tick();
        alloc(1, 4, 0, 0);
        tick();
        alloc(0, 0, 0, 0);
        check("t4_state", 32'(fust_state), 32'h222);
        check("t4_fu0", 32'(issue_fu), 32'h0);
        issue_ready = 1'b1;
        tick();
        check("t4_s0_issued", 32'(st(0)), 32'h3);
        check("t4_fu2", 32'(issue_fu), 32'h2);
        freeze = 1'b1;
        #1;
        check("t4_freeze_valid", 32'(issue_valid), 32'h0);
        tick();
        check("t4_freeze_s2", 32'(st(2)), 32'h2);
        freeze = 1'b0;
        #1;
        check("t4_unfreeze_fu2", 32'(issue_fu), 32'h2);
        tick();
        check("t4_s2_issued", 32'(st(2)), 32'h3);
        check("t4_fu4", 32'(issue_fu), 32'h4);
        tick();
        check("t4_s4_issued", 32'(st(4)), 32'h3);
        check("t4_none", 32'(issue_valid), 32'h0);
        issue_ready = 1'b0;
        done(1, 0);
        alloc(1, 0, 0, 0);
        tick();
        done(0, 0);
        check("t4_done_alloc_s0", 32'(st(0)), 32'h2);
        alloc(1, 3, 0, 0);
        tick();
        alloc(0, 0, 0, 0);
        check("t4_wrap_fu0", 32'(issue_fu), 32'h0);

        // Alloc errors, ignored done, done-then-alloc
        alloc(1, 3, 1, 1);
        tick();
        check("t5_err_busy", 32'(alloc_err), 32'h1);
        check("t5_s3_kept", 32'(st(3)), 32'h2);
        alloc(1, 5, 0, 0);
        tick();
        alloc(0, 0, 0, 0);
        check("t5_err_range", 32'(alloc_err), 32'h1);
        tick();
        check("t5_err_cleared", 32'(alloc_err), 32'h0);
        done(1, 3);
        tick();
        done(0, 0);
        check("t5_done_ignored", 32'(st(3)), 32'h2);
        issue_ready = 1'b1;
        tick();
        check("t5_s0_issued", 32'(st(0)), 32'h3);
        tick();
        issue_ready = 1'b0;
        check("t5_s3_issued", 32'(st(3)), 32'h3);
        done(1, 3);
        alloc(1, 3, 2, 0);
        tick();
        done(0, 0);
        alloc(0, 0, 0, 0);
        check("t5_realloc_wait", 32'(st(3)), 32'h1);
        check("t5_realloc_noerr", 32'(alloc_err), 32'h0);
        wb_en = 1'b1; wb_tag = 2'd2;
        tick();
        wb_en = 1'b0; wb_tag = '0;
        check("t5_s3_woken", 32'(st(3)), 32'h2);

        // Flush: rows 0 WAIT, 1 READY, 2 ISSUED
        done(1, 0);
        alloc(1, 0, 1, 0);
        tick();
        done(1, 4);
        alloc(1, 1, 0, 0);
        tick();
        done(0, 0);
        alloc(0, 0, 0, 0);
        check("t6_pre", 32'(fust_state), 32'h0B9);
        flush = 1'b1;
        issue_ready = 1'b1;
        alloc(1, 0, 0, 0);
        tick();
        flush = 1'b0;
        issue_ready = 1'b0;
        alloc(0, 0, 0, 0);
        check("t6_state", 32'(fust_state), 32'h030);
        check("t6_noerr", 32'(alloc_err), 32'h0);
        check("t6_valid", 32'(issue_valid), 32'h0);
        done(1, 2);
        tick();
        done(0, 0);
        check("t6_final_idle", 32'(fust_state), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
